// File: rtl/frac_rate_meter_pkg.sv
// Shared types and helpers for the fractional rate meter.
package frac_rate_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int MAX_W = 128;

    function automatic int acc_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

    function automatic logic [MAX_W-1:0] all_ones(input int w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/frac_rate_meter_sat_counter.sv
// Up-counter with clear-to-0, load-to-1 and a sticky flag set when an
// increment is requested while already at all-ones (the count never wraps).
module sat_counter
    import frac_rate_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [MAX_W-1:0] ONES_WIDE = all_ones(W);
    localparam logic [W-1:0]     CNT_MAX   = ONES_WIDE[W-1:0];
    localparam logic [W-1:0]     CNT_ONE   = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (load_one) begin
            cnt <= CNT_ONE;
            sat <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) sat <= 1'b1;
            else                cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/frac_rate_meter.sv
// Recovers the average pulse period over 2^WIN_LOG2 pulses as a
// Q(DATA_W).(WIN_LOG2) window sum.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | en low; counters at 0, results held
//   ST_SYNC    | waiting for the reference pulse that opens a window
//   ST_MEASURE | counting cycles; last pulse of a window closes it and
//              | also serves as the next window's reference
module frac_rate_meter
    import frac_rate_meter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       pulse,
    output logic [DATA_W+WIN_LOG2-1:0] period,
    output logic                       valid,
    output logic                       ready,
    output logic                       overflow
);

    localparam int ACC_W  = acc_width(DATA_W, WIN_LOG2);
    localparam int PCNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    state_t            state;
    logic [PCNT_W-1:0] pcnt;
    logic [ACC_W-1:0]  acc;
    logic              acc_sat;
    logic              closing;
    logic              acc_clr;
    logic              acc_one;
    logic              acc_inc;

    assign closing = (state == ST_MEASURE) && en && pulse && (pcnt == PCNT_LAST);
    assign acc_clr = (state == ST_IDLE);
    assign acc_one = ((state == ST_SYNC) && en && pulse) || closing;
    assign acc_inc = (state == ST_MEASURE);

    sat_counter #(.W(ACC_W)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .load_one (acc_one),
        .inc      (acc_inc),
        .cnt      (acc),
        .sat      (acc_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pcnt     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            ready    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pcnt <= '0;
                    if (en) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (pulse) begin
                        pcnt  <= '0;
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        pcnt  <= '0;
                    end else if (closing) begin
                        period   <= acc;
                        overflow <= acc_sat;
                        valid    <= 1'b1;
                        ready    <= 1'b1;
                        pcnt     <= '0;
                    end else if (pulse) begin
                        pcnt <= pcnt + PCNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frac_rate_meter.sv
// Bench for frac_rate_meter: vector table, hand corner sequences and a
// randomized run against a timestamp-queue reference model.
module tb_frac_rate_meter;

    localparam int DW   = 4;
    localparam int WL   = 2;
    localparam int WIN  = 1 << WL;
    localparam int PW   = DW + WL;
    localparam int MAXV = (1 << PW) - 1;
    localparam int NV   = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          pulse;
    logic [PW-1:0] period;
    logic          valid;
    logic          ready;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    frac_rate_meter #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pulse    (pulse),
        .period   (period),
        .valid    (valid),
        .ready    (ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a window is the span between the first and the
    // (WIN+1)-th accepted pulse timestamps.
    int            cyc = 0;
    bit            en_prev = 1'b0;
    int            ts[$];
    logic          exp_valid = 1'b0;
    logic [PW-1:0] exp_period = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_ready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts.delete();
            en_prev    = 1'b0;
            exp_valid  = 1'b0;
            exp_period = '0;
            exp_ovf    = 1'b0;
            exp_ready  = 1'b0;
        end else begin
            int sum;
            int last;
            cyc++;
            exp_valid = 1'b0;
            if (!en) begin
                ts.delete();
            end else if (en_prev && pulse) begin
                ts.push_back(cyc);
                if (ts.size() == WIN + 1) begin
                    sum        = ts[WIN] - ts[0];
                    exp_valid  = 1'b1;
                    exp_ovf    = (sum > MAXV);
                    exp_period = (sum > MAXV) ? PW'(MAXV) : PW'(sum);
                    exp_ready  = 1'b1;
                    last       = ts[WIN];
                    ts.delete();
                    ts.push_back(last);
                end
            end
            en_prev = en;
        end
    end

    always @(negedge clk) begin
        check("model_valid", valid, exp_valid);
        check("model_period", period, exp_period);
        check("model_overflow", overflow, exp_ovf);
        check("model_ready", ready, exp_ready);
    end

    typedef struct packed {
        logic [3:0][7:0] iv;
        logic [7:0]      exp_p;
        logic            exp_o;
    } vec_t;

    vec_t          vec [NV];
    logic          obs_valid;
    logic [PW-1:0] obs_period;
    logic          obs_ovf;
    logic          obs_ready;

    // Capture outputs at the first negedge, then place the next pulse n cycles
    // after the previous one.
    task automatic interval(input int n);
        @(negedge clk);
        obs_valid  = valid;
        obs_period = period;
        obs_ovf    = overflow;
        obs_ready  = ready;
        pulse      = (n == 1);
        for (int c = 1; c < n; c++) begin
            @(negedge clk);
            pulse = (c == n - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{iv: {8'd3,  8'd3,  8'd3,  8'd3 }, exp_p: 8'd12, exp_o: 1'b0};
        vec[1] = '{iv: {8'd3,  8'd3,  8'd3,  8'd3 }, exp_p: 8'd12, exp_o: 1'b0};
        vec[2] = '{iv: {8'd4,  8'd3,  8'd4,  8'd3 }, exp_p: 8'd14, exp_o: 1'b0};
        vec[3] = '{iv: {8'd1,  8'd1,  8'd1,  8'd1 }, exp_p: 8'd4,  exp_o: 1'b0};
        vec[4] = '{iv: {8'd20, 8'd20, 8'd20, 8'd20}, exp_p: 8'd63, exp_o: 1'b1};
        vec[5] = '{iv: {8'd3,  8'd3,  8'd3,  8'd3 }, exp_p: 8'd12, exp_o: 1'b0};
        vec[6] = '{iv: {8'd16, 8'd16, 8'd16, 8'd15}, exp_p: 8'd63, exp_o: 1'b0};
        vec[7] = '{iv: {8'd16, 8'd16, 8'd16, 8'd16}, exp_p: 8'd63, exp_o: 1'b1};
        vec[8] = '{iv: {8'd9,  8'd1,  8'd5,  8'd2 }, exp_p: 8'd17, exp_o: 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        pulse = 1'b0;
        #2;
        check("reset_period", period, 0);
        check("reset_valid", valid, 0);
        check("reset_ready", ready, 0);
        check("reset_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        pulse = 1'b1;

        // Back-to-back windows; each row is checked one cycle after its closing pulse.
        for (int r = 0; r <= NV; r++) begin
            for (int k = 0; k < WIN; k++) begin
                if (r == NV && k > 0) break;
                interval((r == NV) ? 3 : int'(vec[r].iv[k]));
                if (k == 0 && r > 0) begin
                    check("tbl_valid", obs_valid, 1);
                    check("tbl_period", obs_period, vec[r-1].exp_p);
                    check("tbl_overflow", obs_ovf, vec[r-1].exp_o);
                    check("tbl_ready", obs_ready, 1);
                end
            end
        end

        // en dropped two pulses into a window: no result, old period held.
        interval(3);
        @(negedge clk);
        en    = 1'b0;
        pulse = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pulse = c[0];
            check("drop_valid", valid, 0);
            check("drop_period_hold", period, vec[NV-1].exp_p);
        end
        @(negedge clk);
        en    = 1'b1;
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b1;
        for (int k = 0; k < WIN; k++) interval(5);
        interval(4);
        check("resync_valid", obs_valid, 1);
        check("resync_period", obs_period, 20);
        check("resync_overflow", obs_ovf, 0);

        // Asynchronous reset mid-window.
        interval(4);
        interval(4);
        @(negedge clk);
        pulse = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_period", period, 0);
        check("midrst_ready", ready, 0);
        check("midrst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse = 1'b1;
        for (int k = 0; k < WIN; k++) interval(2);
        interval(2);
        check("postrst_valid", obs_valid, 1);
        check("postrst_period", obs_period, 8);
        check("postrst_ready", obs_ready, 1);

        // Randomized segments with differing pulse densities; model checks every cycle.
        for (int s = 0; s < 6; s++) begin
            int prob;
            case (s)
                0: prob = 50;
                1: prob = 30;
                2: prob = 10;
                3: prob = 3;
                4: prob = 100;
                default: prob = 20;
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                en    = ($urandom_range(0, 199) < 197);
                pulse = ($urandom_range(0, 99) < prob);
            end
        end
        @(negedge clk);
        pulse = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
